seg7_step_counter: RTL and testbench

SEG7_STEP_COUNTER -- requirements
Module: seg7_step_counter

---
 rtl/seg7_step_counter.sv | 136 +++++++++++++
 tb/tb_seg7_step_counter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_step_counter.sv
// seg7_step_counter: modulo up/down counter stepped either by a synchronised
// push-button (tick_in) or by an internal prescaler, with a synchronous
// clamped load, a wrap pulse, a sticky wrap flag on dp and a hex 7-segment
// decode of the registered count.
`timescale 1ns/1ps
module seg7_step_counter #(
    parameter int MODULUS     = 8,        // count modulus, 2..16
    parameter int PRESCALE    = 1000000,  // clk cycles per auto step, 1..2^24
    parameter int SYNC_STAGES = 2         // tick_in synchroniser depth, 2..4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       mode_auto,
    input  logic       up,
    input  logic       en,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] count,
    output logic [6:0] seg,
    output logic       dp,
    output logic       wrap
);

    localparam logic [3:0]  MAX_CNT  = 4'(MODULUS - 1);
    localparam logic [4:0]  MOD5     = 5'(MODULUS);
    localparam logic [23:0] PRE_LAST = 24'(PRESCALE - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [23:0]            pre_q, pre_d;
    logic [3:0]             count_q, count_d;
    logic                   dp_q, dp_d;
    logic                   wrap_q, wrap_d;
    logic                   man_step;
    logic                   auto_step;
    logic                   step;

    // Synchronise tick_in and keep one history flop for rising-edge detection.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign man_step  = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign auto_step = (pre_q == PRE_LAST);
    // The synchroniser always runs; only the selected source may step.
    assign step      = en & (mode_auto ? auto_step : man_step);

    // Prescaler: free-runs 0..PRESCALE-1 only in enabled auto mode, else parked at 0.
    always_comb begin
        // NOTE: assigning a default first keeps every path covered, so no latch is inferred.
        pre_d = pre_q + 24'd1;
        if (load || !mode_auto || !en || auto_step) begin
            pre_d = '0;
        end
    end

    // Counter next state: load (clamped) beats step; wraps pulse and set dp.
    always_comb begin
        count_d = count_q;
        dp_d    = dp_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = ({1'b0, load_val} >= MOD5) ? MAX_CNT : load_val;
            dp_d    = 1'b0;
        end else if (step) begin
            if (up) begin
                if (count_q >= MAX_CNT) begin
                    count_d = 4'd0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + 4'd1;
                end
            end else begin
                if (count_q == 4'd0) begin
                    count_d = MAX_CNT;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            dp_d = wrap_d;
        end
    end

    // Counter, prescaler and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q   <= '0;
            count_q <= 4'd0;
            dp_q    <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            count_q <= count_d;
            dp_q    <= dp_d;
            wrap_q  <= wrap_d;
        end
    end

    // Hex decode of the registered count, active-high, seg[0]=a .. seg[6]=g.
    always_comb begin
        seg = 7'h00;
        case (count_q)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

    assign count = count_q;
    assign dp    = dp_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_seg7_step_counter.sv
// Testbench for seg7_step_counter: two instances (MODULUS 8 and 10, both
// PRESCALE 4) share stimulus; expected outputs come from a small bench model,
// are queued when stimulus is driven and compared on the falling clock edge.
`timescale 1ns/1ps
module tb_seg7_step_counter;

    typedef struct packed {
        logic [3:0] cnt;
        logic       wrp;
        logic       dpp;
        logic [6:0] sg;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst, tick_in, mode_auto, up, en, load;
    logic [3:0] load_val;
    logic [3:0] count8, count10;
    logic [6:0] seg8, seg10;
    logic       dp8, dp10, wrap8, wrap10;

    obs_t sb[$];
    obs_t e;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    seg7_step_counter #(.MODULUS(8), .PRESCALE(4), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .rst(rst), .tick_in(tick_in), .mode_auto(mode_auto), .up(up),
        .en(en), .load(load), .load_val(load_val),
        .count(count8), .seg(seg8), .dp(dp8), .wrap(wrap8));

    seg7_step_counter #(.MODULUS(10), .PRESCALE(4), .SYNC_STAGES(2)) dut10 (
        .clk(clk), .rst(rst), .tick_in(tick_in), .mode_auto(mode_auto), .up(up),
        .en(en), .load(load), .load_val(load_val),
        .count(count10), .seg(seg10), .dp(dp10), .wrap(wrap10));

    // ---------------- reference model ----------------
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    function automatic obs_t mk(input logic [3:0] c, input logic w, input logic d);
        return {c, w, d, seg_of(c)};
    endfunction

    function automatic obs_t model_step(input obs_t cur, input logic upv, input int mod);
        logic [3:0] n;
        logic       w;
        w = 1'b0;
        if (upv) begin
            if (int'(cur.cnt) == mod - 1) begin n = 4'd0; w = 1'b1; end
            else n = cur.cnt + 4'd1;
        end else begin
            if (cur.cnt == 4'd0) begin n = 4'(mod - 1); w = 1'b1; end
            else n = cur.cnt - 4'd1;
        end
        return mk(n, w, w);
    endfunction

    function automatic obs_t model_load(input logic [3:0] v, input int mod);
        return mk((int'(v) >= mod) ? 4'(mod - 1) : v, 1'b0, 1'b0);
    endfunction

    function automatic obs_t idle(input obs_t cur);
        return mk(cur.cnt, 1'b0, cur.dpp);
    endfunction

    function automatic obs_t obs8();
        return {count8, wrap8, dp8, seg8};
    endfunction

    function automatic obs_t obs10();
        return {count10, wrap10, dp10, seg10};
    endfunction

    // Stimulus-only helper: reset with current mode/up/en settings kept.
    task automatic apply_reset();
        rst = 1'b1; tick_in = 1'b0; load = 1'b0; load_val = 4'd0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        mode_auto = 1'b0; up = 1'b1; en = 1'b1; load = 1'b0; load_val = 4'd0;
        tick_in = 1'b1; rst = 1'b1;
        sb.push_back(mk(4'd0, 1'b0, 1'b0));
        sb.push_back(mk(4'd0, 1'b0, 1'b0));
        repeat (4) @(negedge clk);
        e = sb.pop_front(); vectors++;
        if (obs8() !== e) begin
            miscompares++; $display("FAIL reset_m8: got %h expected %h", obs8(), e);
        end
        e = sb.pop_front(); vectors++;
        if (obs10() !== e) begin
            miscompares++; $display("FAIL reset_m10: got %h expected %h", obs10(), e);
        end
        tick_in = 1'b0;
    endtask

    task automatic test_manual_up();
        obs_t cur;
        mode_auto = 1'b0; up = 1'b1; en = 1'b1;
        apply_reset();
        @(negedge clk);
        cur = mk(4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick_in = 1'b1;
            cur = model_step(cur, 1'b1, 8);
            sb.push_back(cur);
            repeat (3) @(negedge clk);
            e = sb.pop_front(); vectors++;
            if (obs8() !== e) begin
                miscompares++; $display("FAIL manual_up_step[%0d]: got %h expected %h", i, obs8(), e);
            end
            tick_in = 1'b0;
            cur = idle(cur);
            sb.push_back(cur);
            @(negedge clk);
            e = sb.pop_front(); vectors++;
            if (obs8() !== e) begin
                miscompares++; $display("FAIL manual_up_hold[%0d]: got %h expected %h", i, obs8(), e);
            end
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_down_wrap();
        obs_t cur;
        mode_auto = 1'b0; up = 1'b0; en = 1'b1;
        apply_reset();
        @(negedge clk);
        cur = mk(4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick_in = 1'b1;
            cur = model_step(cur, 1'b0, 10);
            sb.push_back(cur);
            repeat (3) @(negedge clk);
            e = sb.pop_front(); vectors++;
            if (obs10() !== e) begin
                miscompares++; $display("FAIL down_step[%0d]: got %h expected %h", i, obs10(), e);
            end
            tick_in = 1'b0;
            cur = idle(cur);
            sb.push_back(cur);
            @(negedge clk);
            e = sb.pop_front(); vectors++;
            if (obs10() !== e) begin
                miscompares++; $display("FAIL down_hold[%0d]: got %h expected %h", i, obs10(), e);
            end
            repeat (3) @(negedge clk);
        end
    endtask

    // Auto mode: phases of {cycles, mode_auto, en, up, tick_in}.
    task automatic test_auto();
        int   n_tab[6]    = '{14, 10, 6, 8, 3, 5};
        logic md_tab[6]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic en_tab[6]   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic up_tab[6]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic tk_tab[6]   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        obs_t cur;
        int   pre;
        logic stp;
        mode_auto = 1'b1; up = 1'b1; en = 1'b1;
        apply_reset();
        cur = mk(4'd0, 1'b0, 1'b0);
        pre = 0;
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < n_tab[p]; c++) begin
                mode_auto = md_tab[p]; en = en_tab[p]; up = up_tab[p]; tick_in = tk_tab[p];
                stp = md_tab[p] && en_tab[p] && (pre == 3);
                pre = (md_tab[p] && en_tab[p]) ? ((pre == 3) ? 0 : pre + 1) : 0;
                cur = stp ? model_step(cur, up_tab[p], 8) : idle(cur);
                sb.push_back(cur);
                @(negedge clk);
                e = sb.pop_front(); vectors++;
                if (obs8() !== e) begin
                    miscompares++; $display("FAIL auto[p%0d c%0d]: got %h expected %h", p, c, obs8(), e);
                end
            end
        end
        mode_auto = 1'b0; tick_in = 1'b0;
    endtask

    task automatic test_load();
        obs_t cur;
        logic [3:0] lv_tab[3] = '{4'h3, 4'hF, 4'h5};
        logic       md_tab[3] = '{1'b1, 1'b1, 1'b0};
        mode_auto = 1'b0; up = 1'b0; en = 1'b1;
        apply_reset();
        @(negedge clk);
        tick_in = 1'b1;
        cur = model_step(mk(4'd0, 1'b0, 1'b0), 1'b0, 10);
        sb.push_back(cur);
        repeat (3) @(negedge clk);
        e = sb.pop_front(); vectors++;
        if (obs10() !== e) begin
            miscompares++; $display("FAIL load_setup: got %h expected %h", obs10(), e);
        end
        tick_in = 1'b0;
        repeat (4) @(negedge clk);
        // Step up from 9 would wrap; a same-cycle load of 0xC must win and clamp.
        up = 1'b1; tick_in = 1'b1;
        repeat (2) @(negedge clk);
        load = 1'b1; load_val = 4'hC;
        cur = model_load(4'hC, 10);
        sb.push_back(cur);
        @(negedge clk);
        e = sb.pop_front(); vectors++;
        if (obs10() !== e) begin
            miscompares++; $display("FAIL load_priority: got %h expected %h", obs10(), e);
        end
        load = 1'b0; tick_in = 1'b0;
        cur = idle(cur);
        sb.push_back(cur);
        @(negedge clk);
        e = sb.pop_front(); vectors++;
        if (obs10() !== e) begin
            miscompares++; $display("FAIL load_after: got %h expected %h", obs10(), e);
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mode_auto = md_tab[i]; load = 1'b1; load_val = lv_tab[i];
            sb.push_back(model_load(lv_tab[i], 10));
            @(negedge clk);
            e = sb.pop_front(); vectors++;
            if (obs10() !== e) begin
                miscompares++; $display("FAIL load_en0[%0d]: got %h expected %h", i, obs10(), e);
            end
        end
        load = 1'b0; en = 1'b1; mode_auto = 1'b0;
    endtask

    task automatic test_sync();
        obs_t cur;
        mode_auto = 1'b0; up = 1'b1; en = 1'b1;
        apply_reset();
        @(negedge clk);
        cur = mk(4'd0, 1'b0, 1'b0);
        for (int r = 0; r < 2; r++) begin
            tick_in = 1'b1;
            for (int k = 1; k <= 20; k++) begin
                cur = (k == 3) ? model_step(cur, 1'b1, 8) : idle(cur);
                sb.push_back(cur);
                @(negedge clk);
                e = sb.pop_front(); vectors++;
                if (obs8() !== e) begin
                    miscompares++; $display("FAIL sync[r%0d k%0d]: got %h expected %h", r, k, obs8(), e);
                end
            end
            tick_in = 1'b0;
            repeat (5) @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        obs_t cur;
        mode_auto = 1'b0; up = 1'b1; en = 1'b1;
        apply_reset();
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            tick_in = 1'b1;
            repeat (3) @(negedge clk);
            tick_in = 1'b0;
            repeat (4) @(negedge clk);
        end
        sb.push_back(mk(4'd5, 1'b0, 1'b0));
        e = sb.pop_front(); vectors++;
        if (obs8() !== e) begin
            miscompares++; $display("FAIL async_pre: got %h expected %h", obs8(), e);
        end
        // Assert reset between clock edges; outputs must clear before the next edge.
        #2;
        rst = 1'b1; tick_in = 1'b1;
        sb.push_back(mk(4'd0, 1'b0, 1'b0));
        #1;
        e = sb.pop_front(); vectors++;
        if (obs8() !== e) begin
            miscompares++; $display("FAIL async_clear: got %h expected %h", obs8(), e);
        end
        @(negedge clk);
        rst = 1'b0;
        cur = mk(4'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            cur = (k == 3) ? model_step(cur, 1'b1, 8) : idle(cur);
            sb.push_back(cur);
            @(negedge clk);
            e = sb.pop_front(); vectors++;
            if (obs8() !== e) begin
                miscompares++; $display("FAIL async_release[k%0d]: got %h expected %h", k, obs8(), e);
            end
        end
        tick_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_manual_up();
        test_down_wrap();
        test_auto();
        test_load();
        test_sync();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
